// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow pool controller and its slots.
package arrow_pkg;

    typedef enum logic {
        IDLE,
        FLYING
    } slot_state_e;

    localparam int unsigned COORD_W_DEF = 11;
    localparam logic [COORD_W_DEF-1:0] OFFSCREEN = '1;

endpackage

// File: rtl/arrow_slot.sv
// One arrow slot: launch, upward motion per frame, retire at top limit or on crash.
module arrow_slot
    import arrow_pkg::*;
#(
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned TOP_LIMIT = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               launch_i,
    input  logic               crash_i,
    input  logic               startOfFrame_i,
    input  logic [COORD_W-1:0] launchX_i,
    input  logic [COORD_W-1:0] launchY_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               active_o
);

    // Retire threshold is held one bit wider than Y so the sum cannot wrap.
    localparam logic [COORD_W:0] RETIRE_LIM = (COORD_W+1)'(TOP_LIMIT + SPEED);
    localparam logic [COORD_W-1:0] STEP     = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] OFF      = '1;

    slot_state_e       state_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               active_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            x_q      <= OFF;
            y_q      <= OFF;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_i) begin
                        state_q  <= FLYING;
                        x_q      <= launchX_i;
                        y_q      <= launchY_i;
                        active_q <= 1'b1;
                    end
                end
                FLYING: begin
                    if (crash_i || (startOfFrame_i && ({1'b0, y_q} < RETIRE_LIM))) begin
                        state_q  <= IDLE;
                        x_q      <= OFF;
                        y_q      <= OFF;
                        active_q <= 1'b0;
                    end else if (startOfFrame_i) begin
                        y_q <= y_q - STEP;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    x_q      <= OFF;
                    y_q      <= OFF;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign active_o = active_q;

endmodule

// File: rtl/arrow_pool_ctrl.sv
// Arrow pool: fire edge detect, shot cooldown, lowest-free slot allocation.
module arrow_pool_ctrl
    import arrow_pkg::*;
#(
    parameter int unsigned NUM_ARROWS      = 2,
    parameter int unsigned COORD_W         = COORD_W_DEF,
    parameter int unsigned SPEED           = 2,
    parameter int unsigned TOP_LIMIT       = 16,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic                          fireReq,
    input  logic [COORD_W-1:0]            charTopX,
    input  logic [COORD_W-1:0]            charTopY,
    input  logic [NUM_ARROWS-1:0]         crash,
    output logic [NUM_ARROWS*COORD_W-1:0] topLeftX,
    output logic [NUM_ARROWS*COORD_W-1:0] topLeftY,
    output logic [NUM_ARROWS-1:0]         active,
    output logic                          fired
);

    localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);

    logic                  fire_q;
    logic                  fired_q;
    logic [CNT_W-1:0]      cool_q, cool_d;
    logic [NUM_ARROWS-1:0] free;
    logic [NUM_ARROWS-1:0] grant;
    logic [NUM_ARROWS-1:0] launch;
    logic                  fire_evt;
    logic                  accept;

    assign fire_evt = fireReq & ~fire_q;
    assign free     = ~active;
    // Isolate the lowest set bit of the free mask.
    assign grant    = free & (~free + NUM_ARROWS'(1));
    assign accept   = fire_evt && (cool_q == '0) && (|free);
    assign launch   = accept ? grant : '0;

    always_comb begin
        cool_d = cool_q;
        if (accept)
            cool_d = CD_LOAD;
        else if (startOfFrame && (cool_q != '0))
            cool_d = cool_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_q  <= 1'b0;
            fired_q <= 1'b0;
            cool_q  <= '0;
        end else begin
            fire_q  <= fireReq;
            fired_q <= accept;
            cool_q  <= cool_d;
        end
    end

    assign fired = fired_q;

    for (genvar i = 0; i < NUM_ARROWS; i++) begin : g_slot
        arrow_slot #(
            .COORD_W  (COORD_W),
            .SPEED    (SPEED),
            .TOP_LIMIT(TOP_LIMIT)
        ) u_slot (
            .clk           (clk),
            .resetN        (resetN),
            .launch_i      (launch[i]),
            .crash_i       (crash[i]),
            .startOfFrame_i(startOfFrame),
            .launchX_i     (charTopX),
            .launchY_i     (charTopY),
            .x_o           (topLeftX[i*COORD_W +: COORD_W]),
            .y_o           (topLeftY[i*COORD_W +: COORD_W]),
            .active_o      (active[i])
        );
    end

endmodule

// File: tb/tb_arrow_pool_ctrl.sv
// Directed bench for arrow_pool_ctrl with default parameters (2 slots, SPEED 2, TOP 16, cooldown 8).
module tb_arrow_pool_ctrl;

    localparam int unsigned N  = 2;
    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] OFF = '1;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic            fireReq;
    logic [CW-1:0]   charTopX;
    logic [CW-1:0]   charTopY;
    logic [N-1:0]    crash;
    logic [N*CW-1:0] topLeftX;
    logic [N*CW-1:0] topLeftY;
    logic [N-1:0]    active;
    logic            fired;

    int checks = 0;
    int errors = 0;

    arrow_pool_ctrl #(
        .NUM_ARROWS     (N),
        .COORD_W        (CW),
        .SPEED          (2),
        .TOP_LIMIT      (16),
        .COOLDOWN_FRAMES(8)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .fireReq     (fireReq),
        .charTopX    (charTopX),
        .charTopY    (charTopY),
        .crash       (crash),
        .topLeftX    (topLeftX),
        .topLeftY    (topLeftY),
        .active      (active),
        .fired       (fired)
    );

    always #5 clk = ~clk;

    wire [CW-1:0] x0 = topLeftX[0 +: CW];
    wire [CW-1:0] x1 = topLeftX[CW +: CW];
    wire [CW-1:0] y0 = topLeftY[0 +: CW];
    wire [CW-1:0] y1 = topLeftY[CW +: CW];

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; fireReq = 1'b0;
        charTopX = '0; charTopY = '0; crash = '0;
        repeat (2) cycle();
        checks++;
        if (active !== 2'b00 || fired !== 1'b0 || x0 !== OFF || y0 !== OFF || x1 !== OFF || y1 !== OFF) begin
            errors++;
            $display("FAIL reset: active=%b fired=%b x0=%h y0=%h x1=%h y1=%h required active=00 fired=0 coords=7ff",
                     active, fired, x0, y0, x1, y1);
        end
        resetN = 1'b1;
        cycle();
    endtask

    task automatic test_single_fire();
        charTopX = 11'd100; charTopY = 11'd400;
        fireReq = 1'b1;
        cycle();
        checks++;
        if (active !== 2'b01 || fired !== 1'b1 || x0 !== 11'd100 || y0 !== 11'd400) begin
            errors++;
            $display("FAIL single_launch: active=%b fired=%b x0=%0d y0=%0d required 01 1 100 400", active, fired, x0, y0);
        end
        cycle();
        checks++;
        if (fired !== 1'b0) begin
            errors++;
            $display("FAIL fired_one_pulse: fired=%b required 0", fired);
        end
        fireReq = 1'b0;
        repeat (3) frame();
        checks++;
        if (y0 !== 11'd394 || x0 !== 11'd100 || y1 !== OFF) begin
            errors++;
            $display("FAIL motion_3frames: x0=%0d y0=%0d y1=%h required 100 394 7ff", x0, y0, y1);
        end
    endtask

    task automatic test_cooldown();
        fireReq = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b0 || active !== 2'b01) begin
            errors++;
            $display("FAIL cooldown_reject: fired=%b active=%b required 0 01", fired, active);
        end
        fireReq = 1'b0;
        repeat (5) frame();
        charTopX = 11'd200; charTopY = 11'd300;
        fireReq = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b1 || active !== 2'b11 || x1 !== 11'd200 || y1 !== 11'd300 || y0 !== 11'd384) begin
            errors++;
            $display("FAIL cooldown_accept: fired=%b active=%b x1=%0d y1=%0d y0=%0d required 1 11 200 300 384",
                     fired, active, x1, y1, y0);
        end
        fireReq = 1'b0;
        cycle();
    endtask

    task automatic test_no_free();
        repeat (8) frame();
        fireReq = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b0 || active !== 2'b11 || y0 !== 11'd368 || y1 !== 11'd284) begin
            errors++;
            $display("FAIL no_free_reject: fired=%b active=%b y0=%0d y1=%0d required 0 11 368 284", fired, active, y0, y1);
        end
        fireReq = 1'b0;
        cycle();
    endtask

    task automatic test_crash_coincident();
        crash = 2'b01; startOfFrame = 1'b1; fireReq = 1'b1;
        cycle();
        crash = 2'b00; startOfFrame = 1'b0;
        checks++;
        if (active !== 2'b10 || fired !== 1'b0 || x0 !== OFF || y0 !== OFF || y1 !== 11'd282) begin
            errors++;
            $display("FAIL crash_coincident: active=%b fired=%b x0=%h y0=%h y1=%0d required 10 0 7ff 7ff 282",
                     active, fired, x0, y0, y1);
        end
        fireReq = 1'b0;
        charTopX = 11'd50; charTopY = 11'd20;
        cycle();
        fireReq = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b1 || active !== 2'b11 || x0 !== 11'd50 || y0 !== 11'd20) begin
            errors++;
            $display("FAIL relaunch_slot0: fired=%b active=%b x0=%0d y0=%0d required 1 11 50 20", fired, active, x0, y0);
        end
        fireReq = 1'b0;
        cycle();
    endtask

    task automatic test_retire();
        frame();
        checks++;
        if (y0 !== 11'd18 || active !== 2'b11) begin
            errors++;
            $display("FAIL retire_y18: y0=%0d active=%b required 18 11", y0, active);
        end
        frame();
        checks++;
        if (y0 !== 11'd16 || active !== 2'b11) begin
            errors++;
            $display("FAIL retire_y16: y0=%0d active=%b required 16 11", y0, active);
        end
        frame();
        checks++;
        if (active !== 2'b10 || x0 !== OFF || y0 !== OFF || y1 !== 11'd276) begin
            errors++;
            $display("FAIL retire_top: active=%b x0=%h y0=%h y1=%0d required 10 7ff 7ff 276", active, x0, y0, y1);
        end
    endtask

    task automatic test_held_fire();
        int pulses;
        crash = 2'b10;
        cycle();
        crash = 2'b00;
        checks++;
        if (active !== 2'b00 || x1 !== OFF || y1 !== OFF) begin
            errors++;
            $display("FAIL crash_slot1: active=%b x1=%h y1=%h required 00 7ff 7ff", active, x1, y1);
        end
        repeat (5) frame();
        crash = 2'b01;
        cycle();
        crash = 2'b00;
        checks++;
        if (active !== 2'b00 || y0 !== OFF) begin
            errors++;
            $display("FAIL crash_idle_ignored: active=%b y0=%h required 00 7ff", active, y0);
        end
        charTopX = 11'd300; charTopY = 11'd500;
        pulses = 0;
        fireReq = 1'b1;
        cycle();
        if (fired === 1'b1) pulses++;
        for (int unsigned f = 0; f < 50; f++) begin
            frame();
            if (fired === 1'b1) pulses++;
            cycle();
            if (fired === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_fire_pulses: count=%0d required 1", pulses);
        end
        checks++;
        if (active !== 2'b01 || x0 !== 11'd300 || y0 !== 11'd400) begin
            errors++;
            $display("FAIL held_fire_flight: active=%b x0=%0d y0=%0d required 01 300 400", active, x0, y0);
        end
    endtask

    task automatic test_reset_midflight();
        int pulses;
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (active !== 2'b00 || fired !== 1'b0 || x0 !== OFF || y0 !== OFF || x1 !== OFF || y1 !== OFF) begin
            errors++;
            $display("FAIL async_reset: active=%b fired=%b x0=%h y0=%h required 00 0 7ff 7ff", active, fired, x0, y0);
        end
        cycle();
        fireReq = 1'b0;
        cycle();
        resetN = 1'b1;
        pulses = 0;
        repeat (4) begin
            cycle();
            if (fired === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || active !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_quiet: pulses=%0d active=%b required 0 00", pulses, active);
        end
        charTopX = 11'd10; charTopY = 11'd100;
        fireReq = 1'b1;
        cycle();
        checks++;
        if (fired !== 1'b1 || active !== 2'b01 || x0 !== 11'd10 || y0 !== 11'd100) begin
            errors++;
            $display("FAIL post_reset_fire: fired=%b active=%b x0=%0d y0=%0d required 1 01 10 100", fired, active, x0, y0);
        end
        fireReq = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_cooldown();
        test_no_free();
        test_crash_coincident();
        test_retire();
        test_held_fire();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
